arc4_ctrl: RTL and testbench

Sequencer and S-memory arbiter for the ARC4 datapath. It accepts one start request and runs the three ARC4 phases in order: init (S[i]=i), KSA (key schedule) and PRGA (keystream XOR of CT into PT). It uses the codebase en/rdy handshake and grants the single-port 256×8 S memory to exactly one phase at a time. A per-phase watchdog flags a hung sub-block. It sits between the top-level wrapper and the init/ksa/prga instances.

---
 rtl/arc4_ctrl.sv | 118 +++++++++++
 tb/tb_arc4_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_ctrl.sv
// arc4_ctrl: ARC4 phase sequencer (init -> KSA -> PRGA), S-memory arbiter and per-phase watchdog
//   clk, rst                   clock, asynchronous active-high reset
//   en / rdy                   start request (taken only when rdy=1) / controller idle
//   done                       one-cycle pulse when PRGA completes
//   err                        sticky watchdog flag, cleared by rst or the next accepted en
//   phase                      current S grant: 0 none, 1 init, 2 ksa, 3 prga
//   init_/ksa_/prga_en         one-cycle start pulses to the sub-blocks
//   init_/ksa_/prga_rdy        sub-block ready inputs
//   init_/ksa_/prga_addr,
//   _wrdata, _wren             S-port requests from each sub-block
//   s_addr, s_wrdata, s_wren   S-port driven by the granted sub-block only
module arc4_ctrl #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic       done,
  output logic       err,
  output logic [1:0] phase,
  output logic       init_en,
  output logic       ksa_en,
  output logic       prga_en,
  input  logic       init_rdy,
  input  logic       ksa_rdy,
  input  logic       prga_rdy,
  input  logic [7:0] init_addr,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] prga_addr,
  input  logic [7:0] init_wrdata,
  input  logic [7:0] ksa_wrdata,
  input  logic [7:0] prga_wrdata,
  input  logic       init_wren,
  input  logic       ksa_wren,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);
  typedef enum logic [3:0] {
    IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA, DONE, ERR
  } state_t;
  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        rdy_q, done_q, err_q, init_en_q, ksa_en_q, prga_en_q;
  logic [1:0]  phase_q, phase_d;
  logic        active, is_wait, enter_start, cur_rdy, wd;
  always_comb begin
    active = state_q inside {START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA};
    is_wait = state_q inside {WAIT_INIT, WAIT_KSA, WAIT_PRGA};
    // phase_q always tracks the group of state_q, so it selects the active sub-block's ready
    cur_rdy = phase_q == 2'd1 ? init_rdy : phase_q == 2'd2 ? ksa_rdy : prga_rdy;
    wd = active && cnt_q == 13'(TIMEOUT_CYC - 1);
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = en ? START_INIT : IDLE;
      START_INIT: state_d = init_rdy ? WAIT_INIT : START_INIT;
      WAIT_INIT:  state_d = busy_q && init_rdy ? START_KSA : WAIT_INIT;
      START_KSA:  state_d = ksa_rdy ? WAIT_KSA : START_KSA;
      WAIT_KSA:   state_d = busy_q && ksa_rdy ? START_PRGA : WAIT_KSA;
      START_PRGA: state_d = prga_rdy ? WAIT_PRGA : START_PRGA;
      WAIT_PRGA:  state_d = busy_q && prga_rdy ? DONE : WAIT_PRGA;
      default:    state_d = IDLE;
    endcase
    // a hung phase overrides whatever transition would otherwise happen this cycle
    if (wd) state_d = ERR;
    enter_start = state_d != state_q && state_d inside {START_INIT, START_KSA, START_PRGA};
    cnt_d = enter_start || !active ? 13'd0 :
            cnt_q == 13'(TIMEOUT_CYC) ? cnt_q : cnt_q + 13'd1;
    // completion needs a low ready first; a ready that never dropped is not a finished phase
    busy_d = is_wait && (busy_q || !cur_rdy);
    phase_d = state_d inside {START_INIT, WAIT_INIT} ? 2'd1 :
              state_d inside {START_KSA, WAIT_KSA}   ? 2'd2 :
              state_d inside {START_PRGA, WAIT_PRGA} ? 2'd3 : 2'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 13'd0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      phase_q   <= 2'd0;
      init_en_q <= 1'b0;
      ksa_en_q  <= 1'b0;
      prga_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rdy_q     <= state_d == IDLE;
      done_q    <= state_d == DONE;
      err_q     <= state_d == ERR || (err_q && !(state_q == IDLE && en));
      phase_q   <= phase_d;
      init_en_q <= state_q == START_INIT && state_d == WAIT_INIT;
      ksa_en_q  <= state_q == START_KSA && state_d == WAIT_KSA;
      prga_en_q <= state_q == START_PRGA && state_d == WAIT_PRGA;
    end
  end
  always_comb begin
    s_addr   = phase_q == 2'd1 ? init_addr : phase_q == 2'd2 ? ksa_addr :
               phase_q == 2'd3 ? prga_addr : 8'd0;
    s_wrdata = phase_q == 2'd1 ? init_wrdata : phase_q == 2'd2 ? ksa_wrdata :
               phase_q == 2'd3 ? prga_wrdata : 8'd0;
    s_wren   = phase_q == 2'd1 ? init_wren : phase_q == 2'd2 ? ksa_wren :
               phase_q == 2'd3 ? prga_wren : 1'b0;
  end
  assign rdy     = rdy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign phase   = phase_q;
  assign init_en = init_en_q;
  assign ksa_en  = ksa_en_q;
  assign prga_en = prga_en_q;
endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: directed bench for arc4_ctrl with counter-based sub-block stubs
module tb_arc4_ctrl;
  localparam int TO = 4096;
  logic clk = 1'b0;
  logic rst, en, rdy, done, err;
  logic [1:0] phase;
  logic init_en, ksa_en, prga_en, init_rdy, ksa_rdy, prga_rdy;
  logic [7:0] ia, ka, pa, iw, kw, pw, s_addr, s_wrdata;
  logic iwe, kwe, pwe, s_wren;
  logic hold_init, stub_clr;
  int dur[3], pre[3], c[3];
  int tests = 0, fails = 0, cyc = 0;
  int n_ie = 0, n_ke = 0, n_pe = 0, n_done = 0;
  int t_ie = 0, t_ke = 0, t_pe = 0, t_done = 0, t_ph3 = 0, t_err = 0;
  logic [15:0] ptrace = 16'h0;
  logic [1:0] ph_prev = 2'd0;
  logic err_prev = 1'b0;
  logic [7:0] d_addr;
  logic d_wren, d_rdy;

  arc4_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done), .err(err), .phase(phase),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(ia), .ksa_addr(ka), .prga_addr(pa),
    .init_wrdata(iw), .ksa_wrdata(kw), .prga_wrdata(pw),
    .init_wren(iwe), .ksa_wren(kwe), .prga_wren(pwe),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stub: on x_en, stay ready for pre cycles, then drop ready for dur cycles
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst || stub_clr) c[k] <= 0;
      else if ((k == 0 && init_en) || (k == 1 && ksa_en) || (k == 2 && prga_en)) c[k] <= pre[k] + dur[k];
      else if (c[k] != 0) c[k] <= c[k] - 1;
    end
  end
  assign init_rdy = !(c[0] != 0 && c[0] <= dur[0]) && !hold_init;
  assign ksa_rdy  = !(c[1] != 0 && c[1] <= dur[1]);
  assign prga_rdy = !(c[2] != 0 && c[2] <= dur[2]);

  always @(negedge clk) begin
    if (init_en) begin n_ie++; t_ie = cyc; end
    if (ksa_en) begin n_ke++; t_ke = cyc; end
    if (prga_en) begin n_pe++; t_pe = cyc; end
    if (done) begin n_done++; t_done = cyc; d_addr = s_addr; d_wren = s_wren; d_rdy = rdy; end
    if (phase != ph_prev) begin
      ptrace = {ptrace[13:0], phase};
      if (phase == 2'd3) t_ph3 = cyc;
    end
    ph_prev = phase;
    if (err && !err_prev) t_err = cyc;
    err_prev = err;
  end

  typedef struct {
    logic [1:0] ph;
    logic [7:0] ia, ka, pa, iw, kw, pw;
    logic [2:0] we;
    logic [7:0] ea, ed;
    logic       ewe;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_def();
    ia = 8'h11; ka = 8'h22; pa = 8'h33;
    iw = 8'hA1; kw = 8'hA2; pw = 8'hA3;
    iwe = 1'b1; kwe = 1'b1; pwe = 1'b1;
  endtask

  task automatic start(output int t);
    tick();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    t = cyc;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 5000 && phase !== p; i++) tick();
    if (phase !== p) chk("wait_phase_timeout", {30'd0, phase}, {30'd0, p});
  endtask

  task automatic wait_rdy(input string nm);
    for (int i = 0; i < 6000 && rdy !== 1'b1; i++) tick();
    if (rdy !== 1'b1) chk(nm, {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0, b_ie, b_ke, b_pe, b_done;
    vt[0] = '{2'd1, 8'h11, 8'h22, 8'h33, 8'hA1, 8'hA2, 8'hA3, 3'b111, 8'h11, 8'hA1, 1'b1};
    vt[1] = '{2'd1, 8'h5A, 8'h22, 8'h33, 8'h3C, 8'hA2, 8'hA3, 3'b110, 8'h5A, 8'h3C, 1'b0};
    vt[2] = '{2'd2, 8'h11, 8'h22, 8'h33, 8'hA1, 8'hA2, 8'hA3, 3'b111, 8'h22, 8'hA2, 1'b1};
    vt[3] = '{2'd2, 8'h11, 8'hFF, 8'h33, 8'hA1, 8'h00, 8'hA3, 3'b101, 8'hFF, 8'h00, 1'b0};
    vt[4] = '{2'd3, 8'h11, 8'h22, 8'h33, 8'hA1, 8'hA2, 8'hA3, 3'b111, 8'h33, 8'hA3, 1'b1};
    vt[5] = '{2'd3, 8'h11, 8'h22, 8'h80, 8'hA1, 8'hA2, 8'h7E, 3'b011, 8'h80, 8'h7E, 1'b0};
    vt[6] = '{2'd0, 8'h11, 8'h22, 8'h33, 8'hA1, 8'hA2, 8'hA3, 3'b111, 8'h00, 8'h00, 1'b0};
    rst = 1'b1; en = 1'b0; hold_init = 1'b0; stub_clr = 1'b0;
    dur = '{256, 768, 300}; pre = '{0, 0, 0};
    set_def();
    #1;
    chk("reset_rdy", {31'd0, rdy}, 32'd1);
    chk("reset_phase", {30'd0, phase}, 32'd0);
    chk("reset_s_port", {15'd0, s_addr, s_wrdata, s_wren}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_pulses", {28'd0, init_en, ksa_en, prga_en, done}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;

    // full run with arbitration vectors applied inside each phase
    b_ie = n_ie; b_ke = n_ke; b_pe = n_pe; b_done = n_done;
    start(t0);
    chk("run1_rdy_low", {31'd0, rdy}, 32'd0);
    chk("run1_phase1", {30'd0, phase}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      wait_phase(vt[i].ph);
      ia = vt[i].ia; ka = vt[i].ka; pa = vt[i].pa;
      iw = vt[i].iw; kw = vt[i].kw; pw = vt[i].pw;
      {pwe, kwe, iwe} = vt[i].we;
      #1;
      chk($sformatf("mux_vec%0d", i), {15'd0, s_addr, s_wrdata, s_wren}, {15'd0, vt[i].ea, vt[i].ed, vt[i].ewe});
      set_def();
    end
    wait_rdy("run1_rdy_timeout");
    chk("run1_en_counts", {8'd0, 8'(n_ie - b_ie), 8'(n_ke - b_ke), 8'(n_pe - b_pe)}, 32'h00010101);
    chk("run1_done_count", n_done - b_done, 32'd1);
    chk("run1_order", {31'd0, t_ie < t_ke && t_ke < t_pe && t_pe < t_done}, 32'd1);
    chk("run1_latency", t_done - t0, 32'd1333);
    chk("run1_phase_trace", {24'd0, ptrace[7:0]}, 32'h6C);
    chk("run1_done_s_port", {23'd0, d_addr, d_wren}, 32'd0);
    chk("run1_done_rdy", {31'd0, d_rdy}, 32'd0);

    // init_rdy low at start, ksa_rdy lingering high, en ignored while busy
    b_ie = n_ie; b_ke = n_ke; b_pe = n_pe; b_done = n_done;
    hold_init = 1'b1; pre[1] = 5;
    start(t0);
    repeat (10) tick();
    chk("init_en_withheld", n_ie - b_ie, 32'd0);
    chk("hold_phase1", {30'd0, phase}, 32'd1);
    hold_init = 1'b0;
    for (int i = 0; i < 2000 && n_ke == b_ke; i++) tick();
    chk("ksa_en_seen", n_ke - b_ke, 32'd1);
    repeat (5) tick();
    chk("ksa_linger_phase", {30'd0, phase}, 32'd2);
    chk("ksa_linger_no_prga", n_pe - b_pe, 32'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_rdy("run2_rdy_timeout");
    chk("ignored_en_init", n_ie - b_ie, 32'd1);
    chk("ignored_en_done", n_done - b_done, 32'd1);
    chk("run2_latency", t_done - t_ie, 32'd1337);
    chk("run2_phase_trace", {24'd0, ptrace[7:0]}, 32'h6C);

    // watchdog: prga never comes back
    b_done = n_done;
    pre[1] = 0; dur[2] = 100000;
    start(t0);
    for (int i = 0; i < 6000 && err !== 1'b1; i++) tick();
    chk("wd_err_set", {31'd0, err}, 32'd1);
    chk("wd_latency", t_err - t_ph3, TO);
    chk("wd_phase0", {30'd0, phase}, 32'd0);
    chk("wd_rdy_in_err", {31'd0, rdy}, 32'd0);
    chk("wd_no_done", n_done - b_done, 32'd0);
    tick();
    chk("wd_rdy_after", {31'd0, rdy}, 32'd1);
    chk("wd_err_sticky", {31'd0, err}, 32'd1);
    stub_clr = 1'b1;
    tick();
    stub_clr = 1'b0; dur[2] = 300;
    start(t0);
    chk("wd_err_cleared", {31'd0, err}, 32'd0);
    wait_rdy("run3_rdy_timeout");
    chk("wd_rerun_done", n_done - b_done, 32'd1);
    chk("wd_rerun_err", {31'd0, err}, 32'd0);

    // asynchronous reset during WAIT_INIT
    b_ie = n_ie; b_done = n_done;
    start(t0);
    for (int i = 0; i < 100 && n_ie == b_ie; i++) tick();
    repeat (20) tick();
    chk("pre_rst_phase", {30'd0, phase}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdy", {31'd0, rdy}, 32'd1);
    chk("async_rst_phase", {30'd0, phase}, 32'd0);
    chk("async_rst_s_port", {15'd0, s_addr, s_wrdata, s_wren}, 32'd0);
    chk("async_rst_pulses", {27'd0, err, init_en, ksa_en, prga_en, done}, 32'd0);
    tick();
    rst = 1'b0;
    b_ie = n_ie; b_done = n_done;
    start(t0);
    chk("restart_phase1", {30'd0, phase}, 32'd1);
    wait_rdy("run4_rdy_timeout");
    chk("restart_init_en", n_ie - b_ie, 32'd1);
    chk("restart_done", n_done - b_done, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
